div_seq_param: RTL and testbench

Parametrised sequential restoring divider; successor to the fixed 16-bit divider top. Takes a WIDTH-bit dividend and divisor, produces quotient and remainder one bit per clock. A leading-one detector on the dividend skips insignificant high bits, so latency scales with dividend magnitude. Adds divide-by-zero flagging, zero fast-path, clean start/ready handshake and an optional signed mode. Sits in the arithmetic unit as a drop-in replacement for the 16-bit divider top.

---
 rtl/div_seq_param.sv | 182 ++++++++++++++++++
 tb/tb_div_seq_param.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/div_seq_param.sv
// div_seq_param: parametrised sequential restoring divider, one quotient bit per clock.
//
// A leading-one detector on the dividend skips its insignificant high bits, so the
// iteration count equals the number of significant dividend bits (k). Divide-by-zero
// and zero-dividend operations take a one-cycle fast path.
//
// Optional feature: define DIV_SIGNED_EN to honour signed_op (absolute-value
// pre-conversion plus a FIX cycle that restores result signs). Without it every
// operand is treated as unsigned and signed_op is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   start      request, sampled only while ready=1
//   signed_op  signed division request, sampled with start
//   DBus       dividend, sampled with start
//   MBus       divisor, sampled with start
//   quotient   registered quotient
//   remainder  registered remainder
//   ready      idle / result valid
//   dbz        last operation had a zero divisor
module div_seq_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] DBus,
    input  logic [WIDTH-1:0] MBus,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             dbz
);

    typedef enum logic [2:0] {StIdle, StAlign, StIter, StFix, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;          // partial remainder; always < divisor between steps
    logic [WIDTH-1:0] q_q;          // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] m_q;
    logic [CNTW-1:0]  cnt_q;
    logic [CNTW-1:0]  k_q;
    logic             dbz_pend_q;

    logic [WIDTH-1:0] d_abs;
    logic [WIDTH-1:0] m_abs;
    logic [CNTW-1:0]  k_d;

`ifdef DIV_SIGNED_EN
    logic neg_quo_q;
    logic neg_rem_q;
    logic d_neg;
    logic m_neg;

    always_comb begin
        d_neg = signed_op & DBus[WIDTH-1];
        m_neg = signed_op & MBus[WIDTH-1];
        d_abs = d_neg ? -DBus : DBus;
        m_abs = m_neg ? -MBus : MBus;
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;

    always_comb begin
        d_abs = DBus;
        m_abs = MBus;
    end
`endif

    // Leading-one detector: number of significant bits of |dividend|.
    always_comb begin
        k_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d_abs[i]) k_d = CNTW'(i + 1);
        end
    end

    // One restoring step. The shifted partial remainder needs WIDTH+1 bits; the
    // trial subtraction carries one more so its sign bit tells whether it fits.
    logic [WIDTH:0]   a_shift;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic [CNTW-1:0]  shamt;

    always_comb begin
        a_shift  = {a_q, q_q[WIDTH-1]};
        trial    = {1'b0, a_shift} - {2'b00, m_q};
        trial_ok = ~trial[WIDTH+1];
        shamt    = CNTW'(WIDTH) - k_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            q_q        <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            dbz_pend_q <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
            ready      <= 1'b1;
            dbz        <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ready      <= 1'b0;
                        dbz        <= 1'b0;
                        dbz_pend_q <= 1'b0;
                        m_q        <= m_abs;
                        k_q        <= k_d;
`ifdef DIV_SIGNED_EN
                        neg_quo_q  <= d_neg ^ m_neg;
                        neg_rem_q  <= d_neg;
`endif
                        if (MBus == '0) begin
                            // Divisor zero: raw dividend as remainder, no sign fix.
                            q_q        <= '1;
                            a_q        <= DBus;
                            dbz_pend_q <= 1'b1;
                            state_q    <= StDone;
                        end else if (DBus == '0) begin
                            q_q     <= '0;
                            a_q     <= '0;
                            state_q <= StDone;
                        end else begin
                            q_q     <= d_abs;
                            a_q     <= '0;
                            state_q <= StAlign;
                        end
                    end
                end
                StAlign: begin
                    q_q     <= q_q << shamt;
                    cnt_q   <= k_q;
                    state_q <= StIter;
                end
                StIter: begin
                    a_q   <= trial_ok ? trial[WIDTH-1:0] : a_shift[WIDTH-1:0];
                    q_q   <= {q_q[WIDTH-2:0], trial_ok};
                    cnt_q <= cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
`ifdef DIV_SIGNED_EN
                        state_q <= StFix;
`else
                        state_q <= StDone;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                StFix: begin
                    if (neg_quo_q) q_q <= -q_q;
                    if (neg_rem_q) a_q <= -a_q;
                    state_q <= StDone;
                end
`endif
                StDone: begin
                    quotient  <= q_q;
                    remainder <= a_q;
                    dbz       <= dbz_pend_q;
                    ready     <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    ready   <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_param.sv
module tb_div_seq_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_op;
    logic        start16, start32;
    logic [15:0] dbus16, mbus16, q16, r16;
    logic [31:0] dbus32, mbus32, q32, r32;
    logic        rdy16, dbz16, rdy32, dbz32;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_op(signed_op),
        .DBus(dbus16), .MBus(mbus16), .quotient(q16), .remainder(r16),
        .ready(rdy16), .dbz(dbz16)
    );

    div_seq_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .signed_op(signed_op),
        .DBus(dbus32), .MBus(mbus32), .quotient(q32), .remainder(r32),
        .ready(rdy32), .dbz(dbz32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sig_bits(input logic [63:0] v);
        int n = 0;
        while (n < 64 && (v >> n) != 0) n++;
        return n;
    endfunction

    // Reference: plain arithmetic on the operands, latency from the bit count.
    task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input bit sgn,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic [63:0] dz, output int lat);
        logic [63:0] mask;
        longint      sa, sb, mag;
        bit          s_en;
`ifdef DIV_SIGNED_EN
        s_en = 1'b1;
`else
        s_en = 1'b0;
`endif
        mask = (64'd1 << w) - 64'd1;
        dz   = 0;
        if (b == 0) begin
            q = mask; r = a; dz = 1; lat = 1;
        end else if (sgn && s_en) begin
            sa  = a[w-1] ? longint'(a) - (longint'(1) <<< w) : longint'(a);
            sb  = b[w-1] ? longint'(b) - (longint'(1) <<< w) : longint'(b);
            q   = 64'(sa / sb) & mask;
            r   = 64'(sa % sb) & mask;
            mag = sa < 0 ? -sa : sa;
            lat = (mag == 0) ? 1 : sig_bits(64'(mag)) + 3;
        end else begin
            q   = a / b;
            r   = a % b;
            lat = (a == 0) ? 1 : sig_bits(a) + 2 + int'(s_en);
        end
    endtask

    function automatic logic cur_ready(input bit wide);
        return wide ? rdy32 : rdy16;
    endfunction

    // pulse_at > 0: raise start with other operands during that busy cycle.
    task automatic run_op(input string tag, input bit wide, input logic [63:0] a,
                          input logic [63:0] b, input bit sgn, input int pulse_at);
        logic [63:0] eq, er, ed;
        int          elat, n;
        model(wide ? 32 : 16, a, b, sgn, eq, er, ed, elat);
        @(negedge clk);
        signed_op = sgn;
        if (wide) begin dbus32 = a[31:0]; mbus32 = b[31:0]; start32 = 1'b1; end
        else      begin dbus16 = a[15:0]; mbus16 = b[15:0]; start16 = 1'b1; end
        @(negedge clk);
        start16 = 1'b0; start32 = 1'b0;
        n = 0;
        while (cur_ready(wide) == 1'b0 && n < 200) begin
            n++;
            if (n == pulse_at) begin
                dbus16 = 16'd9; mbus16 = 16'd4; start16 = 1'b1;
            end
            @(negedge clk);
            start16 = 1'b0;
        end
        check({tag, " latency"}, 64'(n), 64'(elat));
        if (wide) begin
            check({tag, " quotient"}, 64'(q32), eq);
            check({tag, " remainder"}, 64'(r32), er);
            check({tag, " dbz"}, 64'(dbz32), ed);
        end else begin
            check({tag, " quotient"}, 64'(q16), eq);
            check({tag, " remainder"}, 64'(r16), er);
            check({tag, " dbz"}, 64'(dbz16), ed);
        end
    endtask

    initial begin
        logic [63:0] a, b;
        bit          wide;
        int          w, nb;

        rst = 1'b0; start16 = 1'b0; start32 = 1'b0; signed_op = 1'b0;
        dbus16 = '0; mbus16 = '0; dbus32 = '0; mbus32 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("reset quotient", 64'(q16), 0);
        check("reset remainder", 64'(r16), 0);
        check("reset ready", 64'(rdy16), 1);
        check("reset dbz", 64'(dbz16), 0);
        check("reset ready32", 64'(rdy32), 1);

        run_op("100/7", 0, 100, 7, 0, 0);
        run_op("ffff/1", 0, 16'hFFFF, 1, 0, 0);
        run_op("1234/0", 0, 1234, 0, 0, 0);
        run_op("10/3", 0, 10, 3, 0, 0);
        run_op("0/5", 0, 0, 5, 0, 0);
        run_op("s -7/2", 0, 16'hFFF9, 2, 1, 0);
        run_op("s min/-1", 0, 16'h8000, 16'hFFFF, 1, 0);
        run_op("s 7/-2", 0, 7, 16'hFFFE, 1, 0);
        run_op("s -5/0", 0, 16'hFFFB, 0, 1, 0);
        run_op("busy 50/5", 0, 50, 5, 0, 4);

        // Reset mid-ITER of a long operation.
        @(negedge clk);
        dbus16 = 16'd1000; mbus16 = 16'd3; start16 = 1'b1; signed_op = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst quotient", 64'(q16), 0);
        check("midrst remainder", 64'(r16), 0);
        check("midrst ready", 64'(rdy16), 1);
        check("midrst dbz", 64'(dbz16), 0);

        run_op("200/13", 0, 200, 13, 0, 0);
        run_op("w32 ffffffff/10", 1, 32'hFFFFFFFF, 32'h10, 0, 0);

        for (int i = 0; i < 40; i++) begin
            wide = ($urandom_range(0, 1) == 1);
            w    = wide ? 32 : 16;
            nb   = $urandom_range(0, w);
            a    = 64'($urandom) & ((64'd1 << nb) - 64'd1);
            nb   = $urandom_range(0, w);
            b    = 64'($urandom) & ((64'd1 << nb) - 64'd1);
            run_op("random", wide, a, b, ($urandom_range(0, 1) == 1), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
